// File: rtl/stonyman_roi_capture.sv
// Stonyman sequencer with SPI ADC capture and valid/ready pixel stream.
// Supports runtime ROI, subsample step, single-shot and continuous frames.
module stonyman_roi_capture #(
  parameter int ARRAY_ROWS = 112,
  parameter int ARRAY_COLS = 112,
  parameter int ADDR_W     = 7,
  parameter int STEP_W     = 3,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 16,
  parameter int SCLK_HALF  = 2,
  parameter int ADC_FRAME  = 16,
  parameter int ADC_BITS   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic [ADDR_W-1:0]   cfg_row_start,
  input  logic [ADDR_W-1:0]   cfg_col_start,
  input  logic [ADDR_W-1:0]   cfg_rows,
  input  logic [ADDR_W-1:0]   cfg_cols,
  input  logic [STEP_W-1:0]   cfg_step,
  output logic                resp,
  output logic                incp,
  output logic                resv,
  output logic                incv,
  output logic                inphi,
  output logic                cs,
  output logic                sclk,
  input  logic                miso,
  output logic [ADC_BITS-1:0] pixel_data,
  output logic                pixel_valid,
  input  logic                pixel_ready,
  output logic                pixel_sof,
  output logic                pixel_eol,
  output logic                busy,
  output logic                frame_done,
  output logic                cfg_err,
  output logic [3:0]          tp_state
);

  localparam int W  = ADDR_W + STEP_W + 1;
  localparam int HL = 2 * ADC_FRAME + 1;
  localparam int HW = $clog2(HL + 1);
  localparam logic [15:0] P_HI  = 16'(PULSE_CYC);
  localparam logic [15:0] P_END = 16'(2 * PULSE_CYC - 1);
  localparam logic [15:0] S_END = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] H_END = 16'(SCLK_HALF - 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CHECK    = 4'd1,
    PROG_ROW = 4'd2,
    PROG_COL = 4'd3,
    SETTLE   = 4'd4,
    HOLD     = 4'd5,
    CONV     = 4'd6,
    EMIT     = 4'd7,
    NEXT_COL = 4'd8,
    DONE     = 4'd9
  } state_t;

  state_t state, state_n;
  logic [15:0] tmr, tmr_n;
  logic [1:0] sub, sub_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] r, r_n, c, c_n;
  logic [ADDR_W-1:0] ri, ri_n, ci, ci_n;
  logic [HW-1:0] hc, hc_n;
  logic [ADC_BITS-1:0] sr, sr_n, pix, pix_n;
  logic [ADDR_W-1:0] col0_q, rows_q, cols_q;
  logic [STEP_W-1:0] step_q;
  logic [W-1:0] row_end, col_end;
  logic bad;
  logic [ADDR_W-1:0] need;
  logic [4:0] sel;
  logic hi, pdone;

  // Last addressed row/col computed wide so large counts cannot wrap.
  always_comb begin
    row_end = W'(cfg_row_start)
            + W'(cfg_rows - ONE) * W'(cfg_step);
    col_end = W'(cfg_col_start)
            + W'(cfg_cols - ONE) * W'(cfg_step);
    bad = (cfg_rows == '0) || (cfg_cols == '0)
       || (cfg_step == '0)
       || (row_end >= W'(ARRAY_ROWS))
       || (col_end >= W'(ARRAY_COLS));
  end

  // sel order: resp, incp, resv, incv, inphi
  always_comb begin
    need = '0;
    sel  = '0;
    case (state)
      PROG_ROW: begin
        case (sub)
          2'd0: begin sel = 5'b10000; need = ONE; end
          2'd1: begin sel = 5'b01000; need = ONE; end
          2'd2: begin sel = 5'b00100; need = ONE; end
          default: begin sel = 5'b00010; need = r; end
        endcase
      end
      PROG_COL: begin
        case (sub)
          2'd0: begin sel = 5'b10000; need = ONE; end
          2'd1: begin sel = 5'b00100; need = ONE; end
          default: begin sel = 5'b00010; need = c; end
        endcase
      end
      NEXT_COL: begin
        sel  = 5'b00010;
        need = ADDR_W'(step_q);
      end
      HOLD: begin
        sel  = 5'b00001;
        need = ONE;
      end
      default: ;
    endcase
    hi    = (need != '0) && (tmr < P_HI);
    pdone = (need == '0)
         || ((tmr == P_END) && (cnt == need - ONE));
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    sub_n   = sub;
    cnt_n   = cnt;
    hc_n    = hc;
    r_n     = r;
    c_n     = c;
    ri_n    = ri;
    ci_n    = ci;
    sr_n    = sr;
    pix_n   = pix;
    if (state inside {PROG_ROW, PROG_COL, NEXT_COL, HOLD}) begin
      if (need != '0) begin
        if (tmr == P_END) begin
          tmr_n = '0;
          cnt_n = cnt + ONE;
        end else begin
          tmr_n = tmr + 16'd1;
        end
      end
      if (pdone) begin
        tmr_n = '0;
        cnt_n = '0;
        sub_n = sub + 2'd1;
      end
    end
    case (state)
      IDLE: if (start) state_n = CHECK;
      CHECK: begin
        if (bad) begin
          state_n = IDLE;
        end else begin
          state_n = PROG_ROW;
          r_n  = cfg_row_start;
          c_n  = cfg_col_start;
          ri_n = '0;
          ci_n = '0;
        end
      end
      PROG_ROW: if (pdone && sub == 2'd3) state_n = PROG_COL;
      PROG_COL: if (pdone && sub == 2'd2) state_n = SETTLE;
      NEXT_COL: if (pdone) state_n = SETTLE;
      SETTLE: begin
        if (tmr == S_END) state_n = HOLD;
        else tmr_n = tmr + 16'd1;
      end
      HOLD: if (pdone) state_n = CONV;
      CONV: begin
        if (tmr != H_END) begin
          tmr_n = tmr + 16'd1;
        end else begin
          tmr_n = '0;
          if (hc == HW'(HL)) begin
            pix_n   = sr;
            state_n = EMIT;
          end else begin
            hc_n = hc + HW'(1);
            // odd -> even half is the sclk rising edge
            if (hc[0]) sr_n = {sr[ADC_BITS-2:0], miso};
          end
        end
      end
      EMIT: begin
        if (pixel_ready) begin
          if (ci != cols_q - ONE) begin
            ci_n    = ci + ONE;
            c_n     = c + ADDR_W'(step_q);
            state_n = NEXT_COL;
          end else if (ri != rows_q - ONE) begin
            ri_n    = ri + ONE;
            r_n     = r + ADDR_W'(step_q);
            ci_n    = '0;
            c_n     = col0_q;
            state_n = PROG_ROW;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: state_n = continuous ? CHECK : IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) begin
      tmr_n = '0;
      cnt_n = '0;
      sub_n = '0;
      hc_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      tmr    <= '0;
      sub    <= '0;
      cnt    <= '0;
      hc     <= '0;
      r      <= '0;
      c      <= '0;
      ri     <= '0;
      ci     <= '0;
      sr     <= '0;
      pix    <= '0;
      col0_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      step_q <= '0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      sub   <= sub_n;
      cnt   <= cnt_n;
      hc    <= hc_n;
      r     <= r_n;
      c     <= c_n;
      ri    <= ri_n;
      ci    <= ci_n;
      sr    <= sr_n;
      pix   <= pix_n;
      if (state == CHECK) begin
        col0_q <= cfg_col_start;
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
        step_q <= cfg_step;
      end
    end
  end

  assign {resp, incp, resv, incv, inphi} = hi ? sel : 5'b0;
  assign sclk = (state == CONV) && (hc != '0) && !hc[0];
  assign cs   = !((state == CONV) && (hc != HW'(HL)));
  assign pixel_valid = (state == EMIT);
  assign pixel_sof   = pixel_valid && (ri == '0) && (ci == '0);
  assign pixel_eol   = pixel_valid && (ci == cols_q - ONE);
  assign pixel_data  = pix;
  assign cfg_err     = (state == CHECK) && bad;
  assign busy        = (state != IDLE) && !cfg_err;
  assign frame_done  = (state == DONE);
  assign tp_state    = state;

endmodule

// File: tb/tb_stonyman_roi_capture.sv
// Bench for stonyman_roi_capture: SPI ADC model, pixel scoreboard,
// config legality table and reset/backpressure/continuous sequences.
module tb_stonyman_roi_capture;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [6:0] cfg_row_start = '0;
  logic [6:0] cfg_col_start = '0;
  logic [6:0] cfg_rows = 7'd1;
  logic [6:0] cfg_cols = 7'd1;
  logic [2:0] cfg_step = 3'd1;
  logic resp, incp, resv, incv, inphi;
  logic cs, sclk, miso;
  logic [9:0] pixel_data;
  logic pixel_valid;
  logic pixel_ready = 1'b1;
  logic pixel_sof, pixel_eol;
  logic busy, frame_done, cfg_err;
  logic [3:0] tp_state;

  stonyman_roi_capture dut (
    .clk(clk), .reset(reset), .start(start),
    .continuous(continuous),
    .cfg_row_start(cfg_row_start),
    .cfg_col_start(cfg_col_start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_step(cfg_step),
    .resp(resp), .incp(incp), .resv(resv),
    .incv(incv), .inphi(inphi),
    .cs(cs), .sclk(sclk), .miso(miso),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_sof(pixel_sof), .pixel_eol(pixel_eol),
    .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .tp_state(tp_state)
  );

  always #5 clk = ~clk;

  // ADC model: 16-bit frame, MSB first, shifts on sclk falling edge
  logic [9:0] adc_base = '0;
  logic [15:0] word = '0;
  int conv_count = 0;
  int nf = 0, nf_start = 0, k;
  int sc_total = 0, sc_start = 0, last_sclk = 0;

  always @(negedge cs) begin
    word = {6'h2D, 10'(adc_base + 10'(conv_count))};
    conv_count++;
    nf_start = nf;
    sc_start = sc_total;
  end
  always @(negedge sclk) nf++;
  always @(posedge sclk) if (!cs) sc_total++;
  always @(posedge cs) last_sclk = sc_total - sc_start;
  assign k = nf - nf_start;
  assign miso = (k >= 0 && k < 16) ? word[4'(15 - k)] : 1'b0;

  int n_resp = 0, n_incp = 0, n_resv = 0, n_incv = 0, n_inphi = 0;
  int n_csedge = 0, n_sclkedge = 0;
  always @(posedge resp) n_resp++;
  always @(posedge incp) n_incp++;
  always @(posedge resv) n_resv++;
  always @(posedge incv) n_incv++;
  always @(posedge inphi) n_inphi++;
  always @(cs) n_csedge++;
  always @(sclk) n_sclkedge++;

  typedef struct packed {
    logic [9:0] data;
    logic sof;
    logic eol;
  } pix_t;
  pix_t sb[$];

  typedef struct {
    int rs, c0, rows, cols, step;
    int err;
    int npix;
  } vec_t;
  vec_t tbl[10];

  int passed = 0, total = 0;
  int n_pix, n_done, n_err, n_busy;
  bit excl_bad;
  localparam logic [16:0] IDLE_VEC = 17'h00800;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h",
                  name, act, exp);
  endtask

  function automatic logic [16:0] outv();
    return {tp_state, busy, cs, sclk, resp, incp, resv,
            incv, inphi, pixel_valid, pixel_sof,
            pixel_eol, frame_done, cfg_err};
  endfunction

  function automatic int edges();
    return n_resp + n_incp + n_resv + n_incv + n_inphi
         + n_csedge + n_sclkedge;
  endfunction

  task automatic tick();
    pix_t p;
    @(negedge clk);
    if ($countones({resp, incp, resv, incv, inphi}) > 1)
      excl_bad = 1'b1;
    if (frame_done) n_done++;
    if (cfg_err) n_err++;
    if (busy) n_busy++;
    if (pixel_valid && pixel_ready) begin
      n_pix++;
      if (sb.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        p = sb.pop_front();
        check("pix_data", int'(pixel_data), int'(p.data));
        check("pix_sof_eol", int'({pixel_sof, pixel_eol}),
              int'({p.sof, p.eol}));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_pix = 0;
    n_done = 0;
    n_err = 0;
    n_busy = 0;
    excl_bad = 1'b0;
  endtask

  task automatic set_cfg(int rs, int c0, int rows,
                         int cols, int step);
    cfg_row_start = 7'(rs);
    cfg_col_start = 7'(c0);
    cfg_rows = 7'(rows);
    cfg_cols = 7'(cols);
    cfg_step = 3'(step);
  endtask

  task automatic push_frame(int rows, int cols, int off);
    pix_t p;
    int idx = off;
    for (int i = 0; i < rows; i++)
      for (int j = 0; j < cols; j++) begin
        p.data = 10'(adc_base + 10'(conv_count) + 10'(idx));
        p.sof = (i == 0) && (j == 0);
        p.eol = (j == cols - 1);
        sb.push_back(p);
        idx++;
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int i = 0;
    while (tp_state != 4'd0 && i < 8000) begin
      tick();
      i++;
    end
    check(name, int'(i < 8000), 1);
  endtask

  int s_resp, s_incp, s_resv, s_incv, s_inphi;
  int s_sc, s_edge, vcnt, i;
  bit held;
  logic [9:0] d0;

  initial begin
    tbl[0] = '{110, 0, 2, 1, 2, 1, 0};
    tbl[1] = '{110, 0, 1, 1, 2, 0, 1};
    tbl[2] = '{0, 0, 0, 1, 1, 1, 0};
    tbl[3] = '{0, 0, 1, 0, 1, 1, 0};
    tbl[4] = '{0, 0, 1, 1, 0, 1, 0};
    tbl[5] = '{0, 111, 1, 1, 7, 0, 1};
    tbl[6] = '{0, 100, 1, 3, 6, 1, 0};
    tbl[7] = '{0, 0, 2, 2, 3, 0, 4};
    tbl[8] = '{0, 0, 65, 1, 2, 1, 0};
    tbl[9] = '{108, 0, 2, 1, 3, 0, 2};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(outv()), int'(IDLE_VEC));
    check("reset_pixel_data", int'(pixel_data), 0);
    reset = 1'b1;
    tick();

    // 2x3 ROI with backpressure on the second pixel
    clear_stats();
    s_resp = n_resp; s_incp = n_incp; s_resv = n_resv;
    s_incv = n_incv; s_inphi = n_inphi; s_sc = sc_total;
    set_cfg(5, 10, 2, 3, 1);
    adc_base = 10'(1 - conv_count);
    push_frame(2, 3, 0);
    pulse_start();
    i = 0;
    held = 1'b0;
    while (tp_state != 4'd0 && i < 8000) begin
      if (!held && n_pix == 1) pixel_ready = 1'b0;
      if (!held && !pixel_ready && pixel_valid) begin
        held = 1'b1;
        d0 = pixel_data;
        s_edge = edges();
        vcnt = 0;
        for (int j = 0; j < 20; j++) begin
          tick();
          if (pixel_valid && pixel_data == d0) vcnt++;
        end
        check("bp_valid_held", vcnt, 20);
        check("bp_no_edges", edges() - s_edge, 0);
        pixel_ready = 1'b1;
      end
      tick();
      i++;
    end
    check("roi_finish", int'(i < 8000), 1);
    check("roi_pixels", n_pix, 6);
    check("roi_sb_empty", sb.size(), 0);
    check("roi_resp", n_resp - s_resp, 4);
    check("roi_incp", n_incp - s_incp, 2);
    check("roi_resv", n_resv - s_resv, 4);
    check("roi_incv", n_incv - s_incv, 35);
    check("roi_inphi", n_inphi - s_inphi, 6);
    check("roi_sclk", sc_total - s_sc, 96);
    check("roi_frame_done", n_done, 1);
    check("roi_exclusive", int'(excl_bad), 0);

    // SPI pattern
    clear_stats();
    set_cfg(0, 0, 1, 1, 1);
    adc_base = 10'(10'h2A5 - conv_count);
    push_frame(1, 1, 0);
    pulse_start();
    wait_idle("spi_finish");
    check("spi_sclk_in_cs", last_sclk, 16);
    check("spi_pixels", n_pix, 1);

    // legality table
    for (int t = 0; t < 10; t++) begin
      clear_stats();
      s_edge = edges();
      set_cfg(tbl[t].rs, tbl[t].c0, tbl[t].rows,
              tbl[t].cols, tbl[t].step);
      adc_base = 10'($urandom);
      if (tbl[t].err == 0)
        push_frame(tbl[t].rows, tbl[t].cols, 0);
      pulse_start();
      wait_idle("tbl_finish");
      check($sformatf("tbl%0d_cfg_err", t), n_err, tbl[t].err);
      check($sformatf("tbl%0d_done", t), n_done,
            1 - tbl[t].err);
      check($sformatf("tbl%0d_pixels", t), n_pix, tbl[t].npix);
      if (tbl[t].err != 0) begin
        check($sformatf("tbl%0d_busy", t), n_busy, 0);
        check($sformatf("tbl%0d_edges", t),
              edges() - s_edge, 0);
      end
    end
    check("tbl_sb_empty", sb.size(), 0);

    // continuous 1x1 at the far corner, dropped during frame 3
    clear_stats();
    set_cfg(111, 111, 1, 1, 1);
    adc_base = 10'(10'h155 - conv_count);
    push_frame(1, 1, 0);
    push_frame(1, 1, 1);
    push_frame(1, 1, 2);
    continuous = 1'b1;
    pulse_start();
    i = 0;
    while (n_done < 2 && i < 8000) begin
      tick();
      i++;
    end
    continuous = 1'b0;
    wait_idle("cont_finish");
    check("cont_frames", n_done, 3);
    check("cont_pixels", n_pix, 3);
    check("cont_sb_empty", sb.size(), 0);

    // reset during CONV with sclk high
    clear_stats();
    set_cfg(0, 0, 1, 1, 1);
    pulse_start();
    i = 0;
    while (!(tp_state == 4'd6 && sclk) && i < 2000) begin
      tick();
      i++;
    end
    check("rst_conv_reached", int'(i < 2000), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_conv_outputs", int'(outv()), int'(IDLE_VEC));
    check("rst_conv_pixel_data", int'(pixel_data), 0);
    reset = 1'b1;
    repeat (150) tick();
    check("rst_conv_no_pixel", n_pix, 0);

    // reset during PROG_COL
    clear_stats();
    set_cfg(5, 100, 1, 1, 1);
    pulse_start();
    i = 0;
    while (!(tp_state == 4'd3 && incv) && i < 2000) begin
      tick();
      i++;
    end
    check("rst_col_reached", int'(i < 2000), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_col_outputs", int'(outv()), int'(IDLE_VEC));
    reset = 1'b1;
    repeat (600) tick();
    check("rst_col_no_pixel", n_pix, 0);
    check("rst_col_idle", int'(tp_state), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
